cdc_sync_bus: RTL and testbench

- Parametrised multi-bit synchroniser for the receiving clock domain, with a configurable number of flop stages per bit.
- Optional word-level stability filter: q updates only after the synchronised word has held one value for STABLE_CYCLES consecutive cycles. This lets quasi-static buses (config words, status, Gray counters) cross domains coherently and rejects glitches.
- Per-bit rise/fall pulses and a word-change pulse are generated so downstream logic needs no separate edge detectors.

---
 rtl/cdc_sync_bus.sv | 124 ++++++++++++
 tb/tb_cdc_sync_bus.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_bus.sv
// Multi-bit receiving-domain synchroniser with optional word stability filter and edge pulses.
// Define CDC_SYNC_BUS_GLITCH_CNT_EN to add a saturating count of abandoned filter candidates.
module cdc_sync_bus #(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      STAGES        = 2,
   parameter int unsigned      STABLE_CYCLES = 0,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
   ,
   output logic [15:0]      glitch_cnt
`endif
);

   // Stage 0 is the only flop that samples d; the name suffix keeps the false-path constraint matching.
   logic [STAGES-1:0][WIDTH-1:0] sync_chain_SYNC_ATTR;
   logic [WIDTH-1:0]             s;
   logic [WIDTH-1:0]             q_w;
   logic [WIDTH-1:0]             q_dly_q;
   logic [WIDTH-1:0]             q_dly_d;

`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
   logic                         glitch_inc;
   logic [15:0]                  glitch_cnt_q;
   logic [15:0]                  glitch_cnt_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) sync_chain_SYNC_ATTR <= {STAGES{RESET_VAL}};
      else     sync_chain_SYNC_ATTR <= {sync_chain_SYNC_ATTR[STAGES-2:0], d};
   end

   assign s = sync_chain_SYNC_ATTR[STAGES-1];

   generate
      if (STABLE_CYCLES == 0) begin : g_nofilt
         assign q_w = s;
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
         assign glitch_inc = 1'b0;
`endif
      end else begin : g_filt
         localparam int unsigned      CNT_W    = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

         logic [WIDTH-1:0] cand_q;
         logic [WIDTH-1:0] cand_d;
         logic [WIDTH-1:0] qf_q;
         logic [WIDTH-1:0] qf_d;
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // cand tracks the last synchronised word; q only takes it after an unbroken run.
         always_comb begin
            cand_d = cand_q;
            qf_d   = qf_q;
            cnt_d  = cnt_q;
            if (s != cand_q) begin
               cand_d = s;
               cnt_d  = '0;
            end else if (cand_q != qf_q) begin
               if (cnt_q == CNT_LAST) begin
                  qf_d  = cand_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cand_q <= RESET_VAL;
               qf_q   <= RESET_VAL;
               cnt_q  <= '0;
            end else begin
               cand_q <= cand_d;
               qf_q   <= qf_d;
               cnt_q  <= cnt_d;
            end
         end

         assign q_w = qf_q;
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
         assign glitch_inc = (s != cand_q) && (cand_q != qf_q);
`endif
      end
   endgenerate

   always_comb begin
      q_dly_d = q_w;
   end

   always_ff @(posedge clk) begin
      if (rst) q_dly_q <= RESET_VAL;
      else     q_dly_q <= q_dly_d;
   end

   assign q       = q_w;
   assign rise    = q_w & ~q_dly_q;
   assign fall    = ~q_w & q_dly_q;
   assign changed = |(q_w ^ q_dly_q);

`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
   always_comb begin
      glitch_cnt_d = glitch_cnt_q;
      if (glitch_inc && (glitch_cnt_q != 16'hFFFF)) glitch_cnt_d = glitch_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) glitch_cnt_q <= 16'd0;
      else     glitch_cnt_q <= glitch_cnt_d;
   end

   assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_cdc_sync_bus.sv
// Bench for cdc_sync_bus: five configurations share one stimulus stream and are checked every
// cycle against a run-length model of the synchronised word; directed steps pin exact latencies.
module tb_cdc_sync_bus;

   localparam int NI = 5;

   function automatic int stg_of(input int i);
      case (i)
         0: return 2;
         1: return 3;
         2: return 2;
         3: return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int scy_of(input int i);
      case (i)
         0: return 0;
         1: return 0;
         2: return 3;
         3: return 4;
         default: return 1;
      endcase
   endfunction

   function automatic logic [7:0] rv_of(input int i);
      return (i == 4) ? 8'hC3 : 8'h00;
   endfunction

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d;
   logic [7:0] q_a    [NI];
   logic [7:0] rise_a [NI];
   logic [7:0] fall_a [NI];
   logic       chg_a  [NI];
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
   logic [15:0] gc_a  [NI];
`endif

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      cdc_sync_bus #(
         .WIDTH        (8),
         .STAGES       (stg_of(gi)),
         .STABLE_CYCLES(scy_of(gi)),
         .RESET_VAL    (rv_of(gi))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .d         (d),
         .q         (q_a[gi]),
         .rise      (rise_a[gi]),
         .fall      (fall_a[gi]),
         .changed   (chg_a[gi])
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
         ,
         .glitch_cnt(gc_a[gi])
`endif
      );
   end

   // Model state: s is d seen STAGES edges late (forced to the reset value while a reset is in the
   // window); q follows s once s has shown the same word for STABLE_CYCLES+1 consecutive edges.
   logic [7:0] dh [4];
   logic       rh [4];
   logic [7:0] m_q    [NI];
   logic [7:0] m_qd   [NI];
   logic [7:0] m_s    [NI];
   logic [7:0] m_prev [NI];
   logic [7:0] m_runv [NI];
   int         m_len  [NI];
   int         m_gc   [NI];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      int         st;
      int         sc;
      logic [7:0] rv;
      logic [7:0] s_new;
      logic [7:0] q_new;
      logic       anyr;
      for (int k = 3; k > 0; k--) begin
         dh[k] = dh[k-1];
         rh[k] = rh[k-1];
      end
      dh[0] = d;
      rh[0] = rst;
      for (int i = 0; i < NI; i++) begin
         st   = stg_of(i);
         sc   = scy_of(i);
         rv   = rv_of(i);
         anyr = 1'b0;
         for (int j = 0; j < st; j++) anyr = anyr | rh[j];
         s_new = anyr ? rv : dh[st-1];
         if (rst) begin
            m_q[i]    = rv;
            m_qd[i]   = rv;
            m_s[i]    = rv;
            m_prev[i] = rv;
            m_runv[i] = rv;
            m_len[i]  = 1;
            m_gc[i]   = 0;
         end else begin
            q_new = m_q[i];
            if (sc == 0) begin
               q_new = s_new;
            end else begin
               if ((m_len[i] > sc) && (m_runv[i] != m_q[i])) q_new = m_runv[i];
               // A pending word (last s differing from q) is dropped when s moves on.
               if ((m_s[i] != m_prev[i]) && (m_prev[i] != m_q[i]) && (m_gc[i] < 65535)) m_gc[i]++;
            end
            m_prev[i] = m_s[i];
            if (s_new == m_runv[i]) begin
               if (m_len[i] < 1000) m_len[i]++;
            end else begin
               m_runv[i] = s_new;
               m_len[i]  = 1;
            end
            m_s[i]  = s_new;
            m_qd[i] = m_q[i];
            m_q[i]  = q_new;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("q[%0d]", i), q_a[i], m_q[i]);
         chk($sformatf("rise[%0d]", i), rise_a[i], m_q[i] & ~m_qd[i]);
         chk($sformatf("fall[%0d]", i), fall_a[i], ~m_q[i] & m_qd[i]);
         chk($sformatf("changed[%0d]", i), chg_a[i], (m_q[i] != m_qd[i]));
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
         chk($sformatf("glitch_cnt[%0d]", i), gc_a[i], m_gc[i]);
`endif
      end
   endtask

   task automatic step(input logic [7:0] dv, input logic rv_in);
      d   = dv;
      rst = rv_in;
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic hold(input logic [7:0] dv, input int n);
      for (int k = 0; k < n; k++) step(dv, 1'b0);
   endtask

   logic [7:0] cur;
   logic [7:0] v;
   int         mode;
   int         len;

   initial begin
      for (int k = 0; k < 4; k++) begin
         dh[k] = 8'h00;
         rh[k] = 1'b0;
      end
      d   = 8'hA5;
      rst = 1'b1;

      // Reset with A5 on the bus, release, two-stage pass-through.
      for (int k = 0; k < 3; k++) step(8'hA5, 1'b1);
      chk("rst_q0", q_a[0], 8'h00);
      chk("rst_chg0", chg_a[0], 1'b0);
      step(8'hA5, 1'b0);
      chk("rel1_q0", q_a[0], 8'h00);
      chk("rel1_rise0", rise_a[0], 8'h00);
      step(8'hA5, 1'b0);
      chk("rel2_q0", q_a[0], 8'hA5);
      chk("rel2_rise0", rise_a[0], 8'hA5);
      chk("rel2_fall0", fall_a[0], 8'h00);
      step(8'hA5, 1'b0);
      chk("rel3_rise0", rise_a[0], 8'h00);
      hold(8'hA5, 12);
      hold(8'h00, 12);

      // Three-stage pass-through latency.
      step(8'h0F, 1'b0);
      step(8'h0F, 1'b0);
      chk("s3_e2_q1", q_a[1], 8'h00);
      step(8'h0F, 1'b0);
      chk("s3_e3_q1", q_a[1], 8'h0F);
      chk("s3_e3_rise1", rise_a[1], 8'h0F);
      chk("s3_e3_chg1", chg_a[1], 1'b1);
      step(8'h0F, 1'b0);
      chk("s3_e4_chg1", chg_a[1], 1'b0);
      hold(8'h0F, 10);
      hold(8'h00, 12);

      // Filtered step, STAGES=2, STABLE_CYCLES=3: update on edge 6.
      for (int k = 1; k <= 5; k++) step(8'h5A, 1'b0);
      chk("f_e5_q2", q_a[2], 8'h00);
      step(8'h5A, 1'b0);
      chk("f_e6_q2", q_a[2], 8'h5A);
      chk("f_e6_rise2", rise_a[2], 8'h5A);
      chk("f_e6_fall2", fall_a[2], 8'h00);
      chk("f_e6_chg2", chg_a[2], 1'b1);
      hold(8'h5A, 10);

      // Two-cycle glitch is rejected.
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b0);
      for (int k = 0; k < 15; k++) begin
         step(8'h5A, 1'b0);
         chk("gl_q2", q_a[2], 8'h5A);
         chk("gl_chg2", chg_a[2], 1'b0);
      end
`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
      chk("gl_cnt2", gc_a[2], 16'd1);
`endif

      // Reset while the filter is counting toward 3C.
      for (int k = 0; k < 3; k++) step(8'h3C, 1'b0);
      step(8'h3C, 1'b1);
      chk("mr_q2", q_a[2], 8'h00);
      chk("mr_rise2", rise_a[2], 8'h00);
      chk("mr_fall2", fall_a[2], 8'h00);
      chk("mr_chg2", chg_a[2], 1'b0);
      for (int k = 1; k <= 5; k++) step(8'h3C, 1'b0);
      chk("mr_e5_q2", q_a[2], 8'h00);
      step(8'h3C, 1'b0);
      chk("mr_e6_q2", q_a[2], 8'h3C);
      chk("mr_e6_rise2", rise_a[2], 8'h3C);

      // Randomised segments: holds, short glitches, noise, occasional resets.
      cur = 8'h3C;
      for (int seg = 0; seg < 400; seg++) begin
         mode = $urandom_range(0, 9);
         if (mode < 4) begin
            cur = 8'($urandom);
            hold(cur, $urandom_range(1, 12));
         end else if (mode < 7) begin
            v   = 8'($urandom);
            len = $urandom_range(1, 4);
            hold(v, len);
            hold(cur, $urandom_range(1, 10));
         end else if (mode < 9) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) step(8'($urandom), 1'b0);
            hold(cur, $urandom_range(1, 10));
         end else begin
            len = $urandom_range(1, 2);
            for (int k = 0; k < len; k++) step(8'($urandom), 1'b1);
         end
      end

`ifdef CDC_SYNC_BUS_GLITCH_CNT_EN
      // Continuous word churn: q never moves and the glitch counter saturates.
      step(8'h01, 1'b1);
      step(8'h01, 1'b1);
      for (int k = 0; k < 66000; k++) step((k % 2 == 0) ? 8'h01 : 8'h02, 1'b0);
      chk("sat_q3", q_a[3], 8'h00);
      chk("sat_cnt3", gc_a[3], 16'hFFFF);
      chk("sat_cnt0", gc_a[0], 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
